// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner: per-pin 2-flop sync, debounce and rise/fall edge pulses (rev 1.0).
// Optional interrupt pending/mask logic is enabled by GPIO_INPUT_CONDITIONER_IRQ_EN.
`default_nettype none

module gpio_input_conditioner #(
  parameter int                    GPIO_WIDTH      = 3,
  parameter int                    DEBOUNCE_CYCLES = 500000,
  parameter logic [GPIO_WIDTH-1:0] RESET_LEVEL     = {GPIO_WIDTH{1'b0}}
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [GPIO_WIDTH-1:0] gpio_raw,
  output logic [GPIO_WIDTH-1:0] gpio_debounced,
  output logic [GPIO_WIDTH-1:0] gpio_rise,
  output logic [GPIO_WIDTH-1:0] gpio_fall,
  output logic                  gpio_changed
`ifdef GPIO_INPUT_CONDITIONER_IRQ_EN
  ,
  input  logic [GPIO_WIDTH-1:0] irq_mask,
  input  logic [GPIO_WIDTH-1:0] irq_clear,
  output logic [GPIO_WIDTH-1:0] irq_pending,
  output logic                  irq
`endif
);

  localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } state_e;

  logic [GPIO_WIDTH-1:0] s1_q, s2_q;
  logic [GPIO_WIDTH-1:0] level_w;
  logic [GPIO_WIDTH-1:0] rise_d, fall_d;
  logic [GPIO_WIDTH-1:0] rise_q, fall_q;
  logic                  changed_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q      <= RESET_LEVEL;
      s2_q      <= RESET_LEVEL;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      s1_q      <= gpio_raw;
      s2_q      <= s1_q;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= |(rise_d | fall_d);
    end
  end

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_bit
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             accept_d;

    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      level_d  = level_q;
      accept_d = 1'b0;
      case (state_q)
        ST_STABLE: begin
          if (s2_q[i] != level_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              level_d  = s2_q[i];
              accept_d = 1'b1;
            end else begin
              state_d = ST_SETTLING;
              cnt_d   = CNT_ONE;
            end
          end
        end
        ST_SETTLING: begin
          // Input fell back to the accepted level before the window closed: glitch.
          if (s2_q[i] == level_q) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d  = ST_STABLE;
            cnt_d    = '0;
            level_d  = s2_q[i];
            accept_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      endcase
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state_q <= ST_STABLE;
        cnt_q   <= '0;
        level_q <= RESET_LEVEL[i];
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
      end
    end

    assign level_w[i] = level_q;
    assign rise_d[i]  = accept_d & level_d;
    assign fall_d[i]  = accept_d & ~level_d;
  end

  assign gpio_debounced = level_w;
  assign gpio_rise      = rise_q;
  assign gpio_fall      = fall_q;
  assign gpio_changed   = changed_q;

`ifdef GPIO_INPUT_CONDITIONER_IRQ_EN
  logic [GPIO_WIDTH-1:0] pending_q;
  logic                  irq_q;

  // A new masked edge sets its bit even if software clears it in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= (pending_q & ~irq_clear) | ((rise_q | fall_q) & irq_mask);
      irq_q     <= |pending_q;
    end
  end

  assign irq_pending = pending_q;
  assign irq         = irq_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench: DUT A uses a 4-cycle debounce with RESET_LEVEL 3'b010, DUT B a 1-cycle debounce.
`default_nettype none

module tb_gpio_input_conditioner;

  localparam int W = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] raw_a = '0;
  logic [W-1:0] raw_b = '0;
  logic [W-1:0] deb_a, rise_a, fall_a;
  logic [W-1:0] deb_b, rise_b, fall_b;
  logic         chg_a, chg_b;
`ifdef GPIO_INPUT_CONDITIONER_IRQ_EN
  logic [W-1:0] mask_a  = '0;
  logic [W-1:0] clear_a = '0;
  logic [W-1:0] pend_a, pend_b;
  logic         irq_a, irq_b;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_deb, exp_rise, exp_fall;
  logic         exp_chg;

  always #5 clock = ~clock;

  gpio_input_conditioner #(
    .GPIO_WIDTH(W), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(3'b010)
  ) u_dut_a (
    .clock(clock), .reset(reset), .gpio_raw(raw_a),
    .gpio_debounced(deb_a), .gpio_rise(rise_a), .gpio_fall(fall_a), .gpio_changed(chg_a)
`ifdef GPIO_INPUT_CONDITIONER_IRQ_EN
    , .irq_mask(mask_a), .irq_clear(clear_a), .irq_pending(pend_a), .irq(irq_a)
`endif
  );

  gpio_input_conditioner #(
    .GPIO_WIDTH(W), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(3'b000)
  ) u_dut_b (
    .clock(clock), .reset(reset), .gpio_raw(raw_b),
    .gpio_debounced(deb_b), .gpio_rise(rise_b), .gpio_fall(fall_b), .gpio_changed(chg_b)
`ifdef GPIO_INPUT_CONDITIONER_IRQ_EN
    , .irq_mask(3'b000), .irq_clear(3'b000), .irq_pending(pend_b), .irq(irq_b)
`endif
  );

  task automatic test_reset();
    reset = 1'b0;
    raw_a = 3'b000;
    raw_b = 3'b000;
    repeat (3) @(negedge clock);
    checks++; if (deb_a !== 3'b010) begin errors++; $display("FAIL reset deb_a: got %b want 010", deb_a); end
    checks++; if ({rise_a, fall_a, chg_a} !== 7'd0) begin errors++; $display("FAIL reset pulses_a: got %b want 0", {rise_a, fall_a, chg_a}); end
    checks++; if (deb_b !== 3'b000) begin errors++; $display("FAIL reset deb_b: got %b want 000", deb_b); end
    reset = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clock); @(negedge clock);
      exp_deb  = (k >= 5) ? 3'b000 : 3'b010;
      exp_fall = (k == 5) ? 3'b010 : 3'b000;
      exp_chg  = (k == 5);
      checks++; if (deb_a !== exp_deb) begin errors++; $display("FAIL post_reset E%0d deb: got %b want %b", k, deb_a, exp_deb); end
      checks++; if (fall_a !== exp_fall) begin errors++; $display("FAIL post_reset E%0d fall: got %b want %b", k, fall_a, exp_fall); end
      checks++; if (rise_a !== 3'b000) begin errors++; $display("FAIL post_reset E%0d rise: got %b want 000", k, rise_a); end
      checks++; if (chg_a !== exp_chg) begin errors++; $display("FAIL post_reset E%0d chg: got %b want %b", k, chg_a, exp_chg); end
    end
  endtask

  task automatic test_bounce();
    raw_a = 3'b001;
    for (int k = 0; k <= 9; k++) begin
      @(posedge clock); @(negedge clock);
      checks++; if (deb_a !== 3'b000) begin errors++; $display("FAIL bounce E%0d deb: got %b want 000", k, deb_a); end
      checks++; if ({rise_a, fall_a, chg_a} !== 7'd0) begin errors++; $display("FAIL bounce E%0d pulses: got %b want 0", k, {rise_a, fall_a, chg_a}); end
      if (k == 2) raw_a = 3'b000;
    end
  endtask

  task automatic test_rise();
    raw_a = 3'b001;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clock); @(negedge clock);
      exp_deb  = (k >= 5) ? 3'b001 : 3'b000;
      exp_rise = (k == 5) ? 3'b001 : 3'b000;
      exp_chg  = (k == 5);
      checks++; if (deb_a !== exp_deb) begin errors++; $display("FAIL rise E%0d deb: got %b want %b", k, deb_a, exp_deb); end
      checks++; if (rise_a !== exp_rise) begin errors++; $display("FAIL rise E%0d rise: got %b want %b", k, rise_a, exp_rise); end
      checks++; if (fall_a !== 3'b000) begin errors++; $display("FAIL rise E%0d fall: got %b want 000", k, fall_a); end
      checks++; if (chg_a !== exp_chg) begin errors++; $display("FAIL rise E%0d chg: got %b want %b", k, chg_a, exp_chg); end
    end
  endtask

  task automatic test_simultaneous();
    raw_a = 3'b110;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clock); @(negedge clock);
      exp_deb  = (k >= 5) ? 3'b110 : 3'b001;
      exp_rise = (k == 5) ? 3'b110 : 3'b000;
      exp_fall = (k == 5) ? 3'b001 : 3'b000;
      exp_chg  = (k == 5);
      checks++; if (deb_a !== exp_deb) begin errors++; $display("FAIL simul E%0d deb: got %b want %b", k, deb_a, exp_deb); end
      checks++; if (rise_a !== exp_rise) begin errors++; $display("FAIL simul E%0d rise: got %b want %b", k, rise_a, exp_rise); end
      checks++; if (fall_a !== exp_fall) begin errors++; $display("FAIL simul E%0d fall: got %b want %b", k, fall_a, exp_fall); end
      checks++; if (chg_a !== exp_chg) begin errors++; $display("FAIL simul E%0d chg: got %b want %b", k, chg_a, exp_chg); end
    end
  endtask

  task automatic test_reset_mid();
    raw_a = 3'b001;
    repeat (3) begin
      @(posedge clock); @(negedge clock);
    end
    #2 reset = 1'b0;
    #1;
    checks++; if (deb_a !== 3'b010) begin errors++; $display("FAIL async_reset deb: got %b want 010", deb_a); end
    checks++; if ({rise_a, fall_a, chg_a} !== 7'd0) begin errors++; $display("FAIL async_reset pulses: got %b want 0", {rise_a, fall_a, chg_a}); end
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clock); @(negedge clock);
      exp_deb  = (k >= 5) ? 3'b001 : 3'b010;
      exp_rise = (k == 5) ? 3'b001 : 3'b000;
      exp_fall = (k == 5) ? 3'b010 : 3'b000;
      exp_chg  = (k == 5);
      checks++; if (deb_a !== exp_deb) begin errors++; $display("FAIL rst_mid E%0d deb: got %b want %b", k, deb_a, exp_deb); end
      checks++; if (rise_a !== exp_rise) begin errors++; $display("FAIL rst_mid E%0d rise: got %b want %b", k, rise_a, exp_rise); end
      checks++; if (fall_a !== exp_fall) begin errors++; $display("FAIL rst_mid E%0d fall: got %b want %b", k, fall_a, exp_fall); end
      checks++; if (chg_a !== exp_chg) begin errors++; $display("FAIL rst_mid E%0d chg: got %b want %b", k, chg_a, exp_chg); end
    end
  endtask

  task automatic test_n1();
    raw_b = 3'b001;
    for (int k = 0; k <= 4; k++) begin
      @(posedge clock); @(negedge clock);
      exp_deb  = (k == 2) ? 3'b001 : 3'b000;
      exp_rise = (k == 2) ? 3'b001 : 3'b000;
      exp_fall = (k == 3) ? 3'b001 : 3'b000;
      exp_chg  = (k == 2) || (k == 3);
      checks++; if (deb_b !== exp_deb) begin errors++; $display("FAIL n1 E%0d deb: got %b want %b", k, deb_b, exp_deb); end
      checks++; if (rise_b !== exp_rise) begin errors++; $display("FAIL n1 E%0d rise: got %b want %b", k, rise_b, exp_rise); end
      checks++; if (fall_b !== exp_fall) begin errors++; $display("FAIL n1 E%0d fall: got %b want %b", k, fall_b, exp_fall); end
      checks++; if (chg_b !== exp_chg) begin errors++; $display("FAIL n1 E%0d chg: got %b want %b", k, chg_b, exp_chg); end
      if (k == 0) raw_b = 3'b000;
    end
  endtask

`ifdef GPIO_INPUT_CONDITIONER_IRQ_EN
  task automatic test_irq();
    mask_a = 3'b000;
    raw_a  = 3'b000;
    repeat (8) @(negedge clock);
    checks++; if (pend_a !== 3'b000) begin errors++; $display("FAIL irq_unmasked pend: got %b want 000", pend_a); end
    mask_a = 3'b001;
    raw_a  = 3'b001;
    for (int k = 0; k <= 7; k++) begin
      @(posedge clock); @(negedge clock);
      exp_deb = (k >= 6) ? 3'b001 : 3'b000;
      exp_chg = (k >= 7);
      checks++; if (pend_a !== exp_deb) begin errors++; $display("FAIL irq_rise E%0d pend: got %b want %b", k, pend_a, exp_deb); end
      checks++; if (irq_a !== exp_chg) begin errors++; $display("FAIL irq_rise E%0d irq: got %b want %b", k, irq_a, exp_chg); end
    end
    raw_a = 3'b011;
    repeat (8) @(negedge clock);
    checks++; if (pend_a !== 3'b001) begin errors++; $display("FAIL irq_bit1 pend: got %b want 001", pend_a); end
    raw_a = 3'b010;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clock); @(negedge clock);
      if (k == 5) begin
        checks++; if (fall_a !== 3'b001) begin errors++; $display("FAIL irq_coinc fall: got %b want 001", fall_a); end
        clear_a = 3'b001;
      end
      if (k == 6) begin
        checks++; if (pend_a !== 3'b001) begin errors++; $display("FAIL irq_coinc pend: got %b want 001", pend_a); end
        clear_a = 3'b000;
      end
    end
    repeat (2) @(negedge clock);
    clear_a = 3'b001;
    @(negedge clock);
    clear_a = 3'b000;
    checks++; if (pend_a !== 3'b000) begin errors++; $display("FAIL irq_clear pend: got %b want 000", pend_a); end
    checks++; if (irq_a !== 1'b1) begin errors++; $display("FAIL irq_clear irq_lag: got %b want 1", irq_a); end
    @(negedge clock);
    checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL irq_clear irq: got %b want 0", irq_a); end
  endtask
`endif

  initial begin
    test_reset();
    test_bounce();
    test_rise();
    test_simultaneous();
    test_reset_mid();
    test_n1();
`ifdef GPIO_INPUT_CONDITIONER_IRQ_EN
    test_irq();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
